bus_receiver: RTL and testbench

Receiving end of the 4-source shared bus: accepts one WIDTH-bit word per handshake and delivers it to one of four destination registers (a, b, c, d). The destination is chosen by the same x/y select encoding the bus transfer side uses. The block sits after the shared bus, one holding register deep. Each destination holds its word until its consumer acknowledges it, and back-pressures the bus while a word is parked.

---
 rtl/bus_receiver.sv | 110 +++++++++++
 tb/tb_bus_receiver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_receiver.sv
// bus_receiver: one-deep holding stage that routes bus words to four acknowledged destination registers.
// Optional build macro BUS_RECEIVER_PARITY_EN adds bus_par/par_err and drops words with bad even parity.
module bus_receiver #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus,
    input  logic             x,
    input  logic             y,
    input  logic             bus_valid,
    output logic             bus_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       full,
    input  logic [3:0]       ack,
`ifdef BUS_RECEIVER_PARITY_EN
    input  logic             bus_par,
    output logic             par_err,
`endif
    output logic [CNT_W-1:0] xfer_cnt
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      hold_q, hold_d;
    logic [1:0]            sel_q, sel_d;
    logic [3:0][WIDTH-1:0] dest_q, dest_d;
    logic [3:0]            full_q, full_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  drop_q, drop_d;
`ifdef BUS_RECEIVER_PARITY_EN
    logic                  perr_q, perr_d;
`endif

    // State register; reset discards any held word before it can commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            sel_q   <= '0;
            dest_q  <= '0;
            full_q  <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
`ifdef BUS_RECEIVER_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            dest_q  <= dest_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
`ifdef BUS_RECEIVER_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Accept in IDLE, commit in HOLD once the target slot is free or being acked this edge
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        dest_d  = dest_q;
        full_d  = full_q & ~ack;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
`ifdef BUS_RECEIVER_PARITY_EN
        perr_d  = perr_q;
`endif
        if (state_q == IDLE) begin
            if (bus_valid) begin
                hold_d  = bus;
                sel_d   = {x, y};
                state_d = HOLD;
                drop_d  = 1'b0;
`ifdef BUS_RECEIVER_PARITY_EN
                drop_d  = (^bus) != bus_par;
                perr_d  = perr_q | drop_d;
`endif
            end
        end else if (drop_q) begin
            state_d = IDLE;
            drop_d  = 1'b0;
        end else if (!full_q[sel_q] || ack[sel_q]) begin
            dest_d[sel_q] = hold_q;
            full_d[sel_q] = 1'b1;
            cnt_d         = cnt_q + CNT_W'(1);
            state_d       = IDLE;
        end
    end

    assign bus_ready = (state_q == IDLE);
    assign a         = dest_q[0];
    assign b         = dest_q[1];
    assign c         = dest_q[2];
    assign d         = dest_q[3];
    assign full      = full_q;
    assign xfer_cnt  = cnt_q;
`ifdef BUS_RECEIVER_PARITY_EN
    assign par_err   = perr_q;
`endif
endmodule

// File: tb/tb_bus_receiver.sv
// tb_bus_receiver: scoreboard bench for bus_receiver; build with BUS_RECEIVER_PARITY_EN to cover the parity option.
module tb_bus_receiver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bus = '0;
    logic       x = 1'b0;
    logic       y = 1'b0;
    logic       bus_valid = 1'b0;
    logic       bus_ready;
    logic [3:0] a, b, c, d, full;
    logic [3:0] ack = '0;
    logic [7:0] xfer_cnt;
`ifdef BUS_RECEIVER_PARITY_EN
    logic       bus_par = 1'b0;
    logic       par_err;
`endif
    int         n_cmp = 0;
    int         n_err = 0;
    logic [5:0] sb[$];

    always #5 clk = ~clk;

    bus_receiver #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .x(x), .y(y),
        .bus_valid(bus_valid), .bus_ready(bus_ready),
        .a(a), .b(b), .c(c), .d(d), .full(full), .ack(ack),
`ifdef BUS_RECEIVER_PARITY_EN
        .bus_par(bus_par), .par_err(par_err),
`endif
        .xfer_cnt(xfer_cnt)
    );

    function automatic logic [3:0] dest_of(input logic [1:0] s);
        return s == 2'd0 ? a : s == 2'd1 ? b : s == 2'd2 ? c : d;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    // Handshake one word; returns at the negedge after the accepting edge
    task automatic send(input logic [3:0] w, input logic [1:0] s, input bit good);
        int t = 0;
        bus = w;
        {x, y} = s;
        bus_valid = 1'b1;
`ifdef BUS_RECEIVER_PARITY_EN
        bus_par = good ? ^w : ~(^w);
`endif
        while (bus_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (bus_ready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: bus_ready=%b required 1", bus_ready);
        end
        @(negedge clk);
        bus_valid = 1'b0;
        if (good) sb.push_back({s, w});
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({a, b, c, d} !== 16'h0 || full !== 4'h0 || xfer_cnt !== 8'h0 || bus_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset: abcd=%h full=%b cnt=%0d rdy=%b required 0000 0000 0 1", {a, b, c, d}, full, xfer_cnt, bus_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ws [4] = '{4'h0, 4'h1, 4'h8, 4'hF};
        logic [5:0] e;
        for (int i = 0; i < 4; i++) begin
            send(ws[i], 2'(i), 1'b1);
            n_cmp++;
            if (bus_ready !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_ready_low[%0d]: bus_ready=%b required 0", i, bus_ready);
            end
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (dest_of(e[5:4]) !== e[3:0] || full[e[5:4]] !== 1'b1 || bus_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_commit[%0d]: dest=%h full=%b rdy=%b required %h full bit 1 rdy 1", i, dest_of(e[5:4]), full, bus_ready, e[3:0]);
            end
        end
        n_cmp++;
        if ({a, b, c, d} !== 16'h018F || full !== 4'hF || xfer_cnt !== 8'd4) begin
            n_err++;
            $display("FAIL b2b_final: abcd=%h full=%b cnt=%0d required 018f 1111 4", {a, b, c, d}, full, xfer_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] e;
        send(4'h6, 2'b01, 1'b1);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bus_ready !== 1'b0 || b !== 4'h1 || xfer_cnt !== 8'd4) begin
                n_err++;
                $display("FAIL bp_blocked[%0d]: rdy=%b b=%h cnt=%0d required 0 1 4", i, bus_ready, b, xfer_cnt);
            end
            @(negedge clk);
        end
        ack = 4'b0010;
        @(negedge clk);
        ack = 4'b0000;
        e = sb.pop_front();
        n_cmp++;
        if (b !== e[3:0] || full[1] !== 1'b1 || bus_ready !== 1'b1 || xfer_cnt !== 8'd5) begin
            n_err++;
            $display("FAIL bp_release: b=%h full=%b rdy=%b cnt=%0d required %h full[1]=1 1 5", b, full, bus_ready, xfer_cnt, e[3:0]);
        end
    endtask

    task automatic test_ack_other();
        logic [5:0] e;
        send(4'hA, 2'b01, 1'b1);
        ack = 4'b1000;
        @(negedge clk);
        ack = 4'b0000;
        n_cmp++;
        if (full !== 4'b0111 || d !== 4'hF || b !== 4'h6 || bus_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ack_other: full=%b d=%h b=%h rdy=%b required 0111 f 6 0", full, d, b, bus_ready);
        end
        ack = 4'b0010;
        @(negedge clk);
        ack = 4'b0000;
        e = sb.pop_front();
        n_cmp++;
        if (b !== e[3:0] || full !== 4'b0111 || xfer_cnt !== 8'd6 || d !== 4'hF) begin
            n_err++;
            $display("FAIL ack_other_commit: b=%h full=%b cnt=%0d d=%h required %h 0111 6 f", b, full, xfer_cnt, d, e[3:0]);
        end
    endtask

    task automatic test_reset_hold();
        send(4'h5, 2'b00, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a, b, c, d} !== 16'h0 || full !== 4'h0 || xfer_cnt !== 8'h0 || bus_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hold: abcd=%h full=%b cnt=%0d rdy=%b required 0000 0000 0 1", {a, b, c, d}, full, xfer_cnt, bus_ready);
        end
        rst = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a, b, c, d} !== 16'h0 || full !== 4'h0 || xfer_cnt !== 8'h0) begin
            n_err++;
            $display("FAIL reset_hold_after: abcd=%h full=%b cnt=%0d required 0000 0000 0", {a, b, c, d}, full, xfer_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [5:0] e;
        int exp_cnt = 0;
        do_reset();
        ack = 4'hF;
        for (int i = 0; i < 256; i++) begin
            send(4'($urandom_range(15)), 2'(i % 4), 1'b1);
            @(negedge clk);
            e = sb.pop_front();
            exp_cnt = (exp_cnt + 1) % 256;
            n_cmp++;
            if (dest_of(e[5:4]) !== e[3:0] || xfer_cnt !== 8'(exp_cnt)) begin
                n_err++;
                $display("FAIL wrap[%0d]: dest=%h cnt=%0d required %h %0d", i, dest_of(e[5:4]), xfer_cnt, e[3:0], exp_cnt);
            end
        end
        ack = 4'h0;
        n_cmp++;
        if (xfer_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_zero: cnt=%0d required 0", xfer_cnt);
        end
    endtask

`ifdef BUS_RECEIVER_PARITY_EN
    task automatic test_parity();
        logic [5:0] e;
        do_reset();
        send(4'h8, 2'b10, 1'b0);
        n_cmp++;
        if (par_err !== 1'b1 || bus_ready !== 1'b0) begin
            n_err++;
            $display("FAIL par_accept: par_err=%b rdy=%b required 1 0", par_err, bus_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus_ready !== 1'b1 || c !== 4'h0 || full[2] !== 1'b0 || xfer_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL par_drop: rdy=%b c=%h full=%b cnt=%0d required 1 0 full[2]=0 0", bus_ready, c, full, xfer_cnt);
        end
        send(4'h8, 2'b10, 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if (c !== e[3:0] || full[2] !== 1'b1 || par_err !== 1'b1 || xfer_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL par_good: c=%h full=%b par_err=%b cnt=%0d required %h full[2]=1 1 1", c, full, par_err, xfer_cnt, e[3:0]);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_ack_other();
        test_reset_hold();
        test_wrap();
`ifdef BUS_RECEIVER_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
